load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 17 +
 rtl/mem_lane_format.sv | 40 ++++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and FSM states.
package lsu_pkg;

    // Access size encodings carried on req_size / ram_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/mem_lane_format.sv
// Combinational data formatting between the core and the SRAM:
// store data is replicated onto every byte lane the access could target,
// and right-justified load data is zero- or sign-extended to 32 bits.
module mem_lane_format
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    // Lane placement of store data and extension of load data per access size
    always_comb begin
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & i_rdata[7]}}, i_rdata[7:0]};
            end
            SZ_HALF: begin
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_signed & i_rdata[15]}}, i_rdata[15:0]};
            end
            SZ_WORD: begin
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
            default: begin
                // Reserved size never reaches the RAM (it faults at acceptance)
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a valid/ready request channel to a 1 KiB SRAM
// window. One access in flight: IDLE accepts, ACCESS drives the RAM for a
// single cycle, RESP holds the result until the requester takes it.
// Misaligned, reserved-size and out-of-window requests skip the RAM and
// answer with a fault directly.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        ram_we,
    output logic [1:0]  ram_size,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    lsu_state_e  r_state;
    lsu_state_e  w_next_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [9:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic        w_accept;
    logic        w_align_fault;
    logic        w_window_miss;
    logic        w_fault;
    logic [31:0] w_lane_wdata;
    logic [31:0] w_load_data;

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_fault = r_fault;
    assign w_accept   = req_valid & req_ready;

    // Only the upper address bits select the window; the low 10 bits index the SRAM
    assign w_window_miss = (req_addr[31:10] != BASE_ADDR[31:10]);
    assign w_fault       = w_align_fault | w_window_miss;

    // Alignment / size legality of the incoming request
    always_comb begin
        w_align_fault = 1'b0;
        case (req_size)
            SZ_BYTE: w_align_fault = 1'b0;
            SZ_HALF: w_align_fault = req_addr[0];
            SZ_WORD: w_align_fault = (req_addr[1:0] != 2'b00);
            default: w_align_fault = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_fault ? ST_RESP : ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: w_next_state = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latch at acceptance and load-result capture at the end of ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 10'h000;
            r_wdata  <= 32'h0000_0000;
            r_rdata  <= 32'h0000_0000;
            r_fault  <= 1'b0;
        end else if (w_accept) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr[9:0];
            r_wdata  <= req_wdata;
            r_rdata  <= 32'h0000_0000;
            r_fault  <= w_fault;
        end else if (r_state == ST_ACCESS) begin
            r_rdata  <= r_write ? 32'h0000_0000 : w_load_data;
        end else begin
            r_rdata  <= r_rdata;
        end
    end

    // RAM port: active only during ACCESS; a write is suppressed while rst is high
    always_comb begin
        ram_we    = 1'b0;
        ram_size  = 2'b00;
        ram_addr  = 10'h000;
        ram_wdata = 32'h0000_0000;
        if (r_state == ST_ACCESS) begin
            ram_we    = r_write & ~rst;
            ram_size  = r_size;
            ram_addr  = r_addr;
            ram_wdata = w_lane_wdata;
        end else begin
            ram_we    = 1'b0;
            ram_size  = 2'b00;
            ram_addr  = 10'h000;
            ram_wdata = 32'h0000_0000;
        end
    end

    mem_lane_format u_lane_format (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .i_rdata  (ram_rdata),
        .o_wdata  (w_lane_wdata),
        .o_rdata  (w_load_data)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed SRAM model that
// writes and returns right-justified read data on the falling clock edge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic        ram_we;
    logic [1:0]  ram_size;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [7:0]  mem [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.BASE_ADDR(32'h2000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .ram_we     (ram_we),
        .ram_size   (ram_size),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    function automatic logic [7:0] lane8(input logic [31:0] d, input logic [1:0] l);
        case (l)
            2'd0:    lane8 = d[7:0];
            2'd1:    lane8 = d[15:8];
            2'd2:    lane8 = d[23:16];
            default: lane8 = d[31:24];
        endcase
    endfunction

    // SRAM model: write with the lane picked by the address, read right-justified
    always @(negedge clk) begin
        if (ram_we) begin
            case (ram_size)
                2'b00: mem[ram_addr] <= lane8(ram_wdata, ram_addr[1:0]);
                2'b01: begin
                    mem[{ram_addr[9:1], 1'b0}] <= lane8(ram_wdata, {ram_addr[1], 1'b0});
                    mem[{ram_addr[9:1], 1'b1}] <= lane8(ram_wdata, {ram_addr[1], 1'b1});
                end
                2'b10: begin
                    mem[{ram_addr[9:2], 2'b00}] <= ram_wdata[7:0];
                    mem[{ram_addr[9:2], 2'b01}] <= ram_wdata[15:8];
                    mem[{ram_addr[9:2], 2'b10}] <= ram_wdata[23:16];
                    mem[{ram_addr[9:2], 2'b11}] <= ram_wdata[31:24];
                end
                default: ;
            endcase
        end
        case (ram_size)
            2'b00:   ram_rdata <= {24'h0, mem[ram_addr]};
            2'b01:   ram_rdata <= {16'h0, mem[{ram_addr[9:1], 1'b1}], mem[{ram_addr[9:1], 1'b0}]};
            2'b10:   ram_rdata <= {mem[{ram_addr[9:2], 2'b11}], mem[{ram_addr[9:2], 2'b10}],
                                   mem[{ram_addr[9:2], 2'b01}], mem[{ram_addr[9:2], 2'b00}]};
            default: ram_rdata <= 32'h0;
        endcase
    end

    // One full transaction; request fields are scrambled right after acceptance
    task automatic xfer(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt,
                        output int lat, output int wecnt);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_timeout addr=%h ready=%b required 1", a, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_size = 2'b11; req_signed = ~sg;
        req_addr = 32'hFFFF_FFFF; req_wdata = ~wd;
        lat = 0; wecnt = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (ram_we) wecnt++;
            if (resp_valid) break;
        end
        rd = resp_rdata; flt = resp_fault;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_checks++;
        if (resp_valid !== 1'b0 || resp_fault !== 1'b0) begin
            n_errors++; $display("FAIL reset_resp got valid=%b fault=%b exp 0/0", resp_valid, resp_fault);
        end
        n_checks++;
        if (resp_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=00000000", resp_rdata); end
        n_checks++;
        if (ram_we !== 1'b0 || ram_addr !== 10'h0 || ram_size !== 2'b00) begin
            n_errors++; $display("FAIL reset_ram got we=%b addr=%h size=%b exp 0/000/00", ram_we, ram_addr, ram_size);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic flt; int lat, we;
        xfer(1'b1, 2'b10, 1'b0, 32'h2000_0004, 32'hDEAD_BEEF, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'h0 || flt !== 1'b0 || lat != 2 || we != 1) begin
            n_errors++; $display("FAIL store_word got rd=%h flt=%b lat=%0d we=%0d exp 0/0/2/1", rd, flt, lat, we);
        end
        xfer(1'b0, 2'b10, 1'b0, 32'h2000_0004, 32'h0, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF || flt !== 1'b0 || lat != 2 || we != 0) begin
            n_errors++; $display("FAIL load_word got rd=%h flt=%b lat=%0d we=%0d exp deadbeef/0/2/0", rd, flt, lat, we);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic flt; int lat, we;
        xfer(1'b1, 2'b10, 1'b0, 32'h2000_0010, 32'h1122_3344, rd, flt, lat, we);
        xfer(1'b1, 2'b00, 1'b0, 32'h2000_0011, 32'h0000_00F5, rd, flt, lat, we);
        n_checks++;
        if (we != 1 || flt !== 1'b0) begin n_errors++; $display("FAIL store_byte got we=%0d flt=%b exp 1/0", we, flt); end
        xfer(1'b0, 2'b00, 1'b1, 32'h2000_0011, 32'h0, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'hFFFF_FFF5) begin n_errors++; $display("FAIL load_sbyte got=%h exp=fffffff5", rd); end
        xfer(1'b0, 2'b00, 1'b0, 32'h2000_0011, 32'h0, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'h0000_00F5) begin n_errors++; $display("FAIL load_ubyte got=%h exp=000000f5", rd); end
        xfer(1'b0, 2'b10, 1'b0, 32'h2000_0010, 32'h0, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'h1122_F544) begin n_errors++; $display("FAIL byte_lanes got=%h exp=1122f544", rd); end
        xfer(1'b0, 2'b01, 1'b1, 32'h2000_0010, 32'h0, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'hFFFF_F544) begin n_errors++; $display("FAIL load_shalf got=%h exp=fffff544", rd); end
        xfer(1'b1, 2'b01, 1'b0, 32'h2000_0012, 32'hABCD_8001, rd, flt, lat, we);
        xfer(1'b0, 2'b01, 1'b0, 32'h2000_0012, 32'h0, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'h0000_8001) begin n_errors++; $display("FAIL load_uhalf got=%h exp=00008001", rd); end
        xfer(1'b0, 2'b10, 1'b0, 32'h2000_0010, 32'h0, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'h8001_F544) begin n_errors++; $display("FAIL half_lanes got=%h exp=8001f544", rd); end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic flt; int lat, we;
        xfer(1'b1, 2'b10, 1'b0, 32'h2000_0000, 32'hCAFE_F00D, rd, flt, lat, we);
        xfer(1'b0, 2'b01, 1'b0, 32'h2000_0003, 32'h0, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'h0 || flt !== 1'b1 || lat != 1 || we != 0) begin
            n_errors++; $display("FAIL fault_misaligned got rd=%h flt=%b lat=%0d we=%0d exp 0/1/1/0", rd, flt, lat, we);
        end
        xfer(1'b1, 2'b10, 1'b0, 32'h2000_0400, 32'h5555_AAAA, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'h0 || flt !== 1'b1 || lat != 1 || we != 0) begin
            n_errors++; $display("FAIL fault_window got rd=%h flt=%b lat=%0d we=%0d exp 0/1/1/0", rd, flt, lat, we);
        end
        xfer(1'b1, 2'b11, 1'b0, 32'h2000_0000, 32'h0000_0000, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'h0 || flt !== 1'b1 || lat != 1 || we != 0) begin
            n_errors++; $display("FAIL fault_rsvd got rd=%h flt=%b lat=%0d we=%0d exp 0/1/1/0", rd, flt, lat, we);
        end
        xfer(1'b1, 2'b10, 1'b0, 32'h2000_0002, 32'h0000_0000, rd, flt, lat, we);
        n_checks++;
        if (flt !== 1'b1 || we != 0) begin n_errors++; $display("FAIL fault_word_align got flt=%b we=%0d exp 1/0", flt, we); end
        xfer(1'b0, 2'b10, 1'b0, 32'h2000_0000, 32'h0, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'hCAFE_F00D || flt !== 1'b0) begin
            n_errors++; $display("FAIL fault_no_write got rd=%h flt=%b exp cafef00d/0", rd, flt);
        end
    endtask

    task automatic test_stall();
        int guard;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL stall_idle got ready=%b exp 1", req_ready); end
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h2000_0004; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_addr = 32'h2000_0010;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF || req_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL stall_hold cyc=%0d got valid=%b rd=%h ready=%b exp 1/deadbeef/0",
                         i, resp_valid, resp_rdata, req_ready);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++; $display("FAIL stall_release got valid=%b ready=%b exp 0/1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin n_errors++; $display("FAIL stall_next_accept got ready=%b exp 0", req_ready); end
        guard = 0;
        while (!resp_valid && guard < 10) begin @(negedge clk); guard++; end
        n_checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h8001_F544) begin
            n_errors++; $display("FAIL stall_next_data got valid=%b rd=%h exp 1/8001f544", resp_valid, resp_rdata);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic flt; int lat, we;
        int seen;
        xfer(1'b1, 2'b10, 1'b0, 32'h2000_0008, 32'h0BAD_F00D, rd, flt, lat, we);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h2000_0008; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ram_we !== 1'b0) begin n_errors++; $display("FAIL abort_we got=%b exp 0", ram_we); end
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++; $display("FAIL abort_state got valid=%b ready=%b exp 0/1", resp_valid, req_ready);
        end
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_errors++; $display("FAIL abort_no_resp got=%0d valid cycles exp 0", seen); end
        xfer(1'b0, 2'b10, 1'b0, 32'h2000_0008, 32'h0, rd, flt, lat, we);
        n_checks++;
        if (rd !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL abort_no_commit got=%h exp=0badf00d", rd); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        ram_rdata = 32'h0;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        test_reset();
        test_word();
        test_byte_half();
        test_fault();
        test_stall();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
